pulse_wave_gen: RTL and testbench
=================================

Name: pulse_wave_gen

Overview:
Programmable pulse/square-wave source, successor to the fixed 512-entry square-wave table. It replaces address-driven lookup with an internal phase accumulator, and adds programmable frequency (step), duty cycle and amplitude. Output is a valid/ready sample stream with backpressure. Configuration changes take effect glitch-free, at the period boundary, and the block feeds the mixer/DAC sample path.

Parameters:
width_p, 12, sample width (signed two's complement)
phase_width_p, 16, phase accumulator width; one period = 2^phase_width_p phase units
default_step_p, 128, step after reset (16-bit: 512 samples/period)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
en_i  in  1  run enable
cfg_valid_i  in  1  config offer
cfg_ready_o  out  1  config accept
cfg_step_i  in  phase_width_p  phase increment per sample
cfg_duty_i  in  phase_width_p  high-time threshold in phase units
cfg_amp_i  in  width_p-1  unsigned magnitude
data_o  out  width_p  signed sample
valid_o  out  1  sample valid
ready_i  in  1  downstream accept

Behaviour:
- Single clock clk_i; reset_i is synchronous, active-high. All state is registered.
- Reset values:
  - state=IDLE, valid_o=0, data_o=0, phase=0, no pending config, cfg_ready_o=1.
  - step=default_step_p, duty=2^(phase_width_p-1), amp=2^(width_p-1)-1.
  - With these defaults the block reproduces the legacy 512-point square wave.
- Sample function s(P):
  - P==0 -> 0
  - 0<P<duty -> +amp
  - otherwise -> -amp
  - ±amp is always representable; no saturation logic is needed.
  - duty=0 gives all -amp except the phase-0 sample.
- Phase: P_next = (P + step) mod 2^phase_width_p. wrap = carry-out of that add.
- Transfer = valid_o & ready_i.
- FSM IDLE:
  - valid_o=0, cfg_ready_o=1.
  - Config handshake writes step/duty/amp directly.
  - en_i=1 -> RUN next cycle with P=0, data_o=s(0)=0, valid_o=1.
  - If a config is accepted in the same cycle as en_i=1, the run uses the new values.
- FSM RUN:
  - valid_o=1. data_o and valid_o hold stable while ready_i=0; no samples are dropped or skipped.
  - On transfer with en_i=1: P<=P_next, data_o<=s(P_next).
  - On transfer with en_i=0: go to IDLE, valid_o<=0, P<=0.
  - en_i falling without a transfer: the current sample stays valid until it is taken.
  - Latency: one cycle from transfer to the next sample presented.
- Config while in RUN:
  - cfg_ready_o = !pending.
  - An accepted config goes to shadow registers and sets pending.
  - Pending is applied on the first transfer where wrap=1, or where the active step==0.
  - On that transfer: P<=P_next, and the new duty/amp are used for s(P_next). The new step applies from the following increment. Pending clears.
  - A config accepted on a wrap-transfer cycle does not apply on that wrap. It applies at the next wrap.
  - Entering IDLE with pending set applies the shadow registers immediately and clears pending.
- Reset mid-operation: the next cycle shows full reset state. Pending and shadow are discarded, and valid_o=0 regardless of ready_i.
- step=0 (no pending): data_o constant at s(P), valid every cycle.

Test Plan:
1. Reset, en_i=1, ready_i=1 -> after the first valid: 0, then 255×(+2047), then 256×(-2047); the 513th sample is 0. Period is 512.
2. In default run, drop ready_i for 5 cycles at sample 100 -> data_o/valid_o frozen at +2047; sequence resumes at sample 101 with no gaps or duplicates.
3. IDLE config step=4096, duty=16384, amp=100, then en_i=1 -> repeating period of 16: 0, +100 ×3, -100 ×12.
4. In RUN (default), offer config step=4096, amp=5 at sample 10 -> cfg_ready_o low until the wrap. Samples 10..511 unchanged. The sample after the wrap is 0, followed by 16-sample periods at ±5.
5. Deassert en_i at sample 20 with ready_i=0 for 3 cycles -> valid_o stays 1 until the transfer, then 0. Re-assert en_i -> the first sample is 0 (phase restarted).
6. Assert reset_i in RUN with a pending config -> the next cycle shows valid_o=0, cfg_ready_o=1. Re-enable produces the default 512-point wave, not the discarded config.

Source files
------------

// File: rtl/pulse_wave_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_wave_gen
// Purpose  : Phase-accumulator pulse/square-wave source with programmable
//            step, duty and amplitude, streamed out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_wave_gen #(
    parameter int width_p        = 12,
    parameter int phase_width_p  = 16,
    parameter int default_step_p = 128
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [phase_width_p-1:0] cfg_step_i,
    input  logic [phase_width_p-1:0] cfg_duty_i,
    input  logic [width_p-2:0]       cfg_amp_i,
    output logic [width_p-1:0]       data_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam logic [phase_width_p-1:0] c_def_step = phase_width_p'(default_step_p);
    localparam logic [phase_width_p-1:0] c_def_duty = {1'b1, {(phase_width_p-1){1'b0}}};
    localparam logic [width_p-2:0]       c_def_amp  = {(width_p-1){1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                     state_q;
    logic                       valid_q;
    logic [width_p-1:0]         data_q;
    logic [phase_width_p-1:0]   phase_q;
    logic [phase_width_p-1:0]   step_q;
    logic [phase_width_p-1:0]   duty_q;
    logic [width_p-2:0]         amp_q;
    logic                       pend_q;
    logic [phase_width_p-1:0]   sh_step_q;
    logic [phase_width_p-1:0]   sh_duty_q;
    logic [width_p-2:0]         sh_amp_q;

    logic [phase_width_p:0]     sum_d;
    logic [phase_width_p-1:0]   phase_d;
    logic                       wrap_d;
    logic                       apply_d;
    logic                       xfer_d;
    logic                       cfg_acc_d;
    logic [phase_width_p-1:0]   duty_eff_d;
    logic [width_p-2:0]         amp_eff_d;

    // Sample value for phase p: zero at phase 0, +amp below duty, -amp otherwise.
    function automatic logic [width_p-1:0] sample_f(
        input logic [phase_width_p-1:0] p,
        input logic [phase_width_p-1:0] duty,
        input logic [width_p-2:0]       amp
    );
        logic [width_p-1:0] mag;
        mag = {1'b0, amp};
        if (p == '0) begin
            return '0;
        end else if (p < duty) begin
            return mag;
        end else begin
            return -mag;
        end
    endfunction

    assign sum_d      = {1'b0, phase_q} + {1'b0, step_q};
    assign phase_d    = sum_d[phase_width_p-1:0];
    assign wrap_d     = sum_d[phase_width_p];
    assign xfer_d     = valid_q & ready_i;
    assign cfg_acc_d  = cfg_valid_i & ~pend_q;
    // A pending config lands on a period boundary, or at once when the phase is frozen.
    assign apply_d    = pend_q & (wrap_d | (step_q == '0));
    assign duty_eff_d = apply_d ? sh_duty_q : duty_q;
    assign amp_eff_d  = apply_d ? sh_amp_q  : amp_q;

    assign cfg_ready_o = ~pend_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            data_q    <= '0;
            phase_q   <= '0;
            step_q    <= c_def_step;
            duty_q    <= c_def_duty;
            amp_q     <= c_def_amp;
            pend_q    <= 1'b0;
            sh_step_q <= '0;
            sh_duty_q <= '0;
            sh_amp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_acc_d) begin
                        step_q <= cfg_step_i;
                        duty_q <= cfg_duty_i;
                        amp_q  <= cfg_amp_i;
                    end
                    if (en_i) begin
                        state_q <= RUN;
                        phase_q <= '0;
                        data_q  <= '0;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer_d && en_i) begin
                        phase_q <= phase_d;
                        data_q  <= sample_f(phase_d, duty_eff_d, amp_eff_d);
                        if (apply_d) begin
                            step_q <= sh_step_q;
                            duty_q <= sh_duty_q;
                            amp_q  <= sh_amp_q;
                            pend_q <= 1'b0;
                        end
                    end else if (xfer_d) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        phase_q <= '0;
                        pend_q  <= 1'b0;
                        if (cfg_acc_d) begin
                            step_q <= cfg_step_i;
                            duty_q <= cfg_duty_i;
                            amp_q  <= cfg_amp_i;
                        end else if (pend_q) begin
                            step_q <= sh_step_q;
                            duty_q <= sh_duty_q;
                            amp_q  <= sh_amp_q;
                        end
                    end
                    if (cfg_acc_d && !(xfer_d && !en_i)) begin
                        sh_step_q <= cfg_step_i;
                        sh_duty_q <= cfg_duty_i;
                        sh_amp_q  <= cfg_amp_i;
                        pend_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_wave_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_wave_gen
// Purpose  : Scoreboard bench for pulse_wave_gen against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_wave_gen;

    localparam int PMOD = 65536;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [15:0] cfg_step_i;
    logic [15:0] cfg_duty_i;
    logic [10:0] cfg_amp_i;
    logic [11:0] data_o;
    logic        valid_o;
    logic        ready_i;

    always #5 clk_i = ~clk_i;

    pulse_wave_gen #(
        .width_p        (12),
        .phase_width_p  (16),
        .default_step_p (128)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_step_i  (cfg_step_i),
        .cfg_duty_i  (cfg_duty_i),
        .cfg_amp_i   (cfg_amp_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    // Reference model state, expressed as plain integers.
    bit m_run, m_valid, m_pend;
    int m_p, m_step, m_duty, m_amp, m_sstep, m_sduty, m_samp, m_data;

    function automatic int sfun(int p, int duty, int amp);
        if (p == 0) return 0;
        if (p < duty) return amp;
        return -amp;
    endfunction

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_valid = 0; m_pend = 0; m_p = 0; m_data = 0;
        m_step = 128; m_duty = 32768; m_amp = 2047;
        m_sstep = 0; m_sduty = 0; m_samp = 0;
        exp_q.delete();
    endtask

    // Predicts the effect of the next clock edge given the inputs now driven.
    task automatic model_update();
        bit acc;
        int sum;
        if (reset_i) begin
            model_reset();
        end else if (!m_run) begin
            if (cfg_valid_i) begin
                m_step = cfg_step_i; m_duty = cfg_duty_i; m_amp = cfg_amp_i;
            end
            if (en_i) begin
                m_run = 1; m_p = 0; m_valid = 1; m_data = 0;
                exp_q.push_back(0);
            end
        end else begin
            acc = cfg_valid_i && !m_pend;
            if (m_valid && ready_i) begin
                if (en_i) begin
                    sum = m_p + m_step;
                    if (m_pend && (sum >= PMOD || m_step == 0)) begin
                        m_step = m_sstep; m_duty = m_sduty; m_amp = m_samp; m_pend = 0;
                    end
                    m_p = sum % PMOD;
                    m_data = sfun(m_p, m_duty, m_amp);
                    exp_q.push_back(m_data);
                end else begin
                    m_run = 0; m_valid = 0; m_p = 0;
                    if (m_pend) begin
                        m_step = m_sstep; m_duty = m_sduty; m_amp = m_samp; m_pend = 0;
                    end
                    if (acc) begin
                        m_step = cfg_step_i; m_duty = cfg_duty_i; m_amp = cfg_amp_i; acc = 0;
                    end
                end
            end
            if (acc) begin
                m_sstep = cfg_step_i; m_sduty = cfg_duty_i; m_samp = cfg_amp_i; m_pend = 1;
            end
        end
    endtask

    task automatic drive(bit rst, bit en, bit rdy, bit cv, int cs, int cd, int ca);
        @(posedge clk_i);
        #1;
        check("valid_o", int'(valid_o), int'(m_valid));
        check("cfg_ready_o", int'(cfg_ready_o), int'(!m_pend));
        if (m_valid) check("data_o", $signed(data_o), m_data);
        reset_i     = rst;
        en_i        = en;
        ready_i     = rdy;
        cfg_valid_i = cv;
        cfg_step_i  = 16'(cs);
        cfg_duty_i  = 16'(cd);
        cfg_amp_i   = 11'(ca);
        model_update();
    endtask

    task automatic run(int n, bit en, bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, en, rdy, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic random_phase(int n);
        bit r, e, rd, c;
        int st;
        for (int i = 0; i < n; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 19) != 0);
            rd = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 5))
                0: st = 0;
                1: st = 128;
                2: st = 4096;
                3: st = 8192;
                4: st = 32768;
                default: st = int'($urandom_range(1024, 65535));
            endcase
            drive(r, e, rd, c, st, int'($urandom_range(0, 65535)), int'($urandom_range(0, 2047)));
        end
    endtask

    // Monitor: every transfer must match the next expected sample in order.
    always @(negedge clk_i) begin
        if (!reset_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream: got %0d, expected no sample at %0t", $signed(data_o), $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("stream", $signed(data_o), e);
            end
        end
    end

    initial begin
        reset_i = 1'b1; en_i = 1'b0; ready_i = 1'b0; cfg_valid_i = 1'b0;
        cfg_step_i = '0; cfg_duty_i = '0; cfg_amp_i = '0;
        model_reset();

        // Default 512-point wave, one full period plus a few samples
        do_reset();
        run(520, 1'b1, 1'b1);

        // Backpressure hold around sample 100
        do_reset();
        run(101, 1'b1, 1'b1);
        run(5, 1'b1, 1'b0);
        run(30, 1'b1, 1'b1);

        // Config in IDLE, then run the 16-sample period
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4096, 16384, 100);
        run(40, 1'b1, 1'b1);

        // Config offered mid-run applies at the wrap
        do_reset();
        run(11, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4096, 32768, 5);
        run(560, 1'b1, 1'b1);

        // en_i falls while stalled; phase restarts on re-enable
        do_reset();
        run(20, 1'b1, 1'b1);
        run(3, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1);
        run(2, 1'b0, 1'b1);
        run(10, 1'b1, 1'b1);

        // Reset with a pending config discards it
        do_reset();
        run(10, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4096, 16384, 9);
        run(5, 1'b1, 1'b1);
        do_reset();
        run(520, 1'b1, 1'b1);

        // Randomized traffic
        random_phase(2500);

        @(posedge clk_i);
        #1;
        check("queue_len", exp_q.size(), m_valid ? 1 : 0);
        check("valid_o_end", int'(valid_o), int'(m_valid));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
